pic27_irq_sequencer: RTL and testbench
======================================

// Module: pic27_irq_sequencer
// PURPOSE
//  Sequential front-end for the 27-channel priority interrupt datapath: 3 priority buses (A>B>C) x 9 channels.
//  Captures request edges into sticky pending bits, applies a per-channel mask and picks one winner.
//  Offers the winner on a valid/ack handshake, then holds service until end-of-interrupt (EOI).
//  Sits between the raw peripheral request lines and the CPU interrupt interface.
// PARAMETERS
//  N_CH   9  channels per priority bus
//  N_LVL  3  priority buses; level 0 (A) is highest
//  VEC_W  4  channel-index width, = clog2(N_CH)
// PORTS
//  clk         in   1        sole clock; all state updates on rising edge
//  rst         in   1        synchronous, active-high reset
//  req_a       in   N_CH     bus A request lines (level 0)
//  req_b       in   N_CH     bus B request lines (level 1)
//  req_c       in   N_CH     bus C request lines (level 2)
//  enable      in   1        global arbitration enable
//  mask_we     in   1        write strobe for mask register
//  mask_wdata  in   27       new mask; bit = lvl*9+ch; 1 = masked
//  mask_q      out  27       current mask register
//  pending_q   out  27       current sticky pending bits, same bit mapping
//  irq_valid   out  1        winner offered
//  irq_level   out  2        winner bus index 0..2
//  irq_vec     out  VEC_W    winner channel index 0..8
//  irq_ack     in   1        CPU accepts offer
//  eoi         in   1        CPU end-of-interrupt
//  busy        out  1        in ARB, OFFER or SERVICE
// BEHAVIOUR
//  Reset: state=IDLE; pending_q=0; mask_q=27'h7FFFFFF (all masked); req_d history=0;
//   irq_valid=0; irq_level=0; irq_vec=0; busy=0.
//  Capture: pending[i] is set when req[i]&~req_d[i] (rising edge); req_d is updated every cycle.
//   pending[i] is cleared only by an accepted offer on bit i.
//   If a new edge and the clear hit the same bit in the same cycle, set wins.
//  Mask: mask_we loads mask_wdata on the next edge. Masking never clears pending bits; it only hides them from arbitration.
//  Eligible vector: elig = pending & ~mask.
//  FSM, one transition per clock:
//   IDLE:    enable && |elig -> ARB; otherwise stay.
//   ARB:     registers the winner (lowest level with an eligible bit, then lowest channel in that level) -> OFFER.
//            If elig became 0 (mask write) -> IDLE, no offer.
//   OFFER:   irq_valid=1; irq_level and irq_vec held stable, with no withdrawal even if the bit is masked meanwhile.
//            irq_ack -> clear that pending bit, go to SERVICE.
//   SERVICE: irq_valid=0; wait for eoi -> IDLE.
//  Latency: request edge sampled at clock edge k -> pending set at k -> ARB at k+1 -> irq_valid high after k+2.
//  Back-to-back: after eoi, the next offer follows 2 clocks later (IDLE->ARB->OFFER). No preemption in SERVICE.
//  eoi outside SERVICE and irq_ack outside OFFER are ignored.
//  enable=0 only blocks IDLE->ARB; OFFER/SERVICE in progress complete normally.
//  rst mid-operation: immediate return to reset values on that edge; an outstanding offer is dropped.
//  Width rule: winner index = lvl*9+ch, computed in 5 bits and never wraps (max 26).
// STRUCTURE
//  Package pic27_pkg: N_CH, N_LVL, VEC_W, IRQ_W=27, state enum {IDLE,ARB,OFFER,SERVICE}, function idx(lvl,ch).
//  Sub-module pic27_prio_enc: combinational 27-bit fixed-priority encoder.
//   In: elig. Out: any, lvl[1:0], ch[VEC_W-1:0].
//   Instantiated once; its outputs are registered in ARB.
//  Top level holds the capture/edge logic, mask register, FSM and handshake outputs.
// TESTING
//  1. Reset, mask=0, pulse req_b[4] -> irq_valid after 3 edges, level=1, vec=4; ack -> pending_q[13]=0, busy until eoi.
//  2. Same cycle: req_c[0], req_a[7], req_a[2] -> offer order A2, A7, C0, each after ack+eoi.
//  3. Mask bit 2 (A2) with A2 and B0 pending -> B0 offered; unmask after eoi -> A2 offered next.
//  4. Mask-write the offered bit during OFFER -> level/vec unchanged until ack; pending bit cleared on ack.
//  5. Hold req_a[0] high across ack -> no re-pend; drop and re-raise it in the ack cycle -> pending_q[0]=1 (set wins).
//  6. Assert rst in SERVICE and in OFFER -> all outputs at reset values, mask=all ones; enable=0 with pending -> stays IDLE.

Source files
------------

// File: rtl/pic27_pkg.sv
// pic27_pkg: shared sizes, state encoding and flat-index helper for the 27-channel interrupt sequencer
package pic27_pkg;
    localparam int N_CH  = 9;
    localparam int N_LVL = 3;
    localparam int VEC_W = 4;
    localparam int IRQ_W = 27;
    typedef enum logic [1:0] {IDLE, ARB, OFFER, SERVICE} state_t;
    function automatic logic [4:0] idx(input logic [1:0] lvl, input logic [VEC_W-1:0] ch);
        return 5'(lvl) * 5'd9 + 5'(ch);
    endfunction
endpackage

// File: rtl/pic27_prio_enc.sv
// pic27_prio_enc: fixed-priority encoder, lowest flat index (level first, then channel) wins
module pic27_prio_enc
    import pic27_pkg::*;
(
    input  logic [IRQ_W-1:0] i_elig,
    output logic             o_any,
    output logic [1:0]       o_lvl,
    output logic [VEC_W-1:0] o_ch
);
    always_comb begin
        o_any = |i_elig;
        o_lvl = '0;
        o_ch  = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (i_elig[i]) begin
                o_lvl = 2'(i / N_CH);
                o_ch  = VEC_W'(i % N_CH);
            end
        end
    end
endmodule

// File: rtl/pic27_irq_sequencer.sv
// pic27_irq_sequencer: edge capture, masking, arbitration and valid/ack/EOI handshake for 3x9 interrupt lines
module pic27_irq_sequencer
    import pic27_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  i_req_a,
    input  logic [N_CH-1:0]  i_req_b,
    input  logic [N_CH-1:0]  i_req_c,
    input  logic             i_enable,
    input  logic             i_mask_we,
    input  logic [IRQ_W-1:0] i_mask_wdata,
    output logic [IRQ_W-1:0] o_mask_q,
    output logic [IRQ_W-1:0] o_pending_q,
    output logic             o_irq_valid,
    output logic [1:0]       o_irq_level,
    output logic [VEC_W-1:0] o_irq_vec,
    input  logic             i_irq_ack,
    input  logic             i_eoi,
    output logic             o_busy
);
    state_t             r_state, w_next;
    logic [IRQ_W-1:0]   r_req_d, r_pending, r_mask;
    logic [1:0]         r_lvl;
    logic [VEC_W-1:0]   r_vec;
    logic [IRQ_W-1:0]   w_req, w_rise, w_elig, w_clr;
    logic               w_any, w_accept;
    logic [1:0]         w_lvl;
    logic [VEC_W-1:0]   w_ch;

    assign w_req    = {i_req_c, i_req_b, i_req_a};
    assign w_rise   = w_req & ~r_req_d;
    assign w_elig   = r_pending & ~r_mask;
    assign w_accept = (r_state == OFFER) && i_irq_ack;
    assign w_clr    = w_accept ? (IRQ_W'(1) << idx(r_lvl, r_vec)) : '0;

    pic27_prio_enc u_enc (
        .i_elig (w_elig),
        .o_any  (w_any),
        .o_lvl  (w_lvl),
        .o_ch   (w_ch)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (i_enable && w_any) ? ARB : IDLE;
            ARB:     w_next = w_any ? OFFER : IDLE;
            OFFER:   w_next = i_irq_ack ? SERVICE : OFFER;
            SERVICE: w_next = i_eoi ? IDLE : SERVICE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req_d   <= '0;
            r_pending <= '0;
            r_mask    <= '1;
            r_lvl     <= '0;
            r_vec     <= '0;
        end else begin
            r_state   <= w_next;
            r_req_d   <= w_req;
            // a fresh edge on the bit being acknowledged must survive the clear
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (i_mask_we) r_mask <= i_mask_wdata;
            if (r_state == ARB && w_any) begin
                r_lvl <= w_lvl;
                r_vec <= w_ch;
            end
        end
    end

    assign o_mask_q    = r_mask;
    assign o_pending_q = r_pending;
    assign o_irq_valid = (r_state == OFFER);
    assign o_irq_level = r_lvl;
    assign o_irq_vec   = r_vec;
    assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_pic27_irq_sequencer.sv
// tb_pic27_irq_sequencer: directed self-checking bench for the interrupt sequencer
module tb_pic27_irq_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  req_a = '0, req_b = '0, req_c = '0;
    logic        enable = 1'b0, mask_we = 1'b0, irq_ack = 1'b0, eoi = 1'b0;
    logic [26:0] mask_wdata = '0;
    logic [26:0] mask_q, pending_q;
    logic        irq_valid, busy;
    logic [1:0]  irq_level;
    logic [3:0]  irq_vec;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    pic27_irq_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_c      (req_c),
        .i_enable     (enable),
        .i_mask_we    (mask_we),
        .i_mask_wdata (mask_wdata),
        .o_mask_q     (mask_q),
        .o_pending_q  (pending_q),
        .o_irq_valid  (irq_valid),
        .o_irq_level  (irq_level),
        .o_irq_vec    (irq_vec),
        .i_irq_ack    (irq_ack),
        .i_eoi        (eoi),
        .o_busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(irq_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mask"}, 32'(mask_q), 32'h7FFFFFF);
        chk({tag, "_pend"}, 32'(pending_q), 32'd0);
        chk({tag, "_lvl"}, 32'(irq_level), 32'd0);
        chk({tag, "_vec"}, 32'(irq_vec), 32'd0);
    endtask

    task automatic chk_offer(input string tag, input logic [1:0] lvl, input logic [3:0] vec);
        chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
        chk({tag, "_lvl"}, 32'(irq_level), 32'(lvl));
        chk({tag, "_vec"}, 32'(irq_vec), 32'(vec));
    endtask

    task automatic write_mask(input logic [26:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic serve();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        enable = 1'b1;

        // single request on B4 (flat bit 13)
        write_mask(27'd0);
        chk("t1_mask", 32'(mask_q), 32'd0);
        req_b[4] = 1'b1;
        tick();
        req_b[4] = 1'b0;
        chk("t1_pend", 32'(pending_q), 32'h2000);
        chk("t1_valid_k", 32'(irq_valid), 32'd0);
        tick();
        chk("t1_busy_arb", 32'(busy), 32'd1);
        chk("t1_valid_k1", 32'(irq_valid), 32'd0);
        tick();
        chk_offer("t1_offer", 2'd1, 4'd4);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t1_pend_ack", 32'(pending_q), 32'd0);
        chk("t1_valid_svc", 32'(irq_valid), 32'd0);
        tick();
        chk("t1_busy_svc", 32'(busy), 32'd1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t1_busy_eoi", 32'(busy), 32'd0);

        // simultaneous C0, A7, A2
        req_a = 9'h084;
        req_c = 9'h001;
        tick();
        req_a = '0;
        req_c = '0;
        chk("t2_pend", 32'(pending_q), 32'h40084);
        tick();
        tick();
        chk_offer("t2_a2", 2'd0, 4'd2);
        serve();
        tick();
        tick();
        chk_offer("t2_a7", 2'd0, 4'd7);
        serve();
        tick();
        tick();
        chk_offer("t2_c0", 2'd2, 4'd0);
        serve();
        chk("t2_pend_end", 32'(pending_q), 32'd0);

        // masked A2 loses to B0, then wins once unmasked
        mask_we = 1'b1;
        mask_wdata = 27'd4;
        req_a[2] = 1'b1;
        req_b[0] = 1'b1;
        tick();
        mask_we = 1'b0;
        req_a[2] = 1'b0;
        req_b[0] = 1'b0;
        chk("t3_pend", 32'(pending_q), 32'h204);
        tick();
        tick();
        chk_offer("t3_b0", 2'd1, 4'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t3_pend_a2", 32'(pending_q), 32'h4);
        eoi = 1'b1;
        mask_we = 1'b1;
        mask_wdata = 27'd0;
        tick();
        eoi = 1'b0;
        mask_we = 1'b0;
        tick();
        tick();
        chk_offer("t3_a2", 2'd0, 4'd2);
        serve();

        // mask the offered bit (C8, top index 26) while offering
        req_c[8] = 1'b1;
        tick();
        req_c[8] = 1'b0;
        tick();
        tick();
        chk_offer("t4_c8", 2'd2, 4'd8);
        write_mask(27'h4000000);
        chk_offer("t4_hold", 2'd2, 4'd8);
        chk("t4_mask", 32'(mask_q), 32'h4000000);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t4_pend_ack", 32'(pending_q), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        write_mask(27'd0);

        // level-held request does not re-pend; re-raise in ack cycle does
        req_a[0] = 1'b1;
        tick();
        tick();
        tick();
        chk_offer("t5_a0", 2'd0, 4'd0);
        serve();
        chk("t5_pend_hold", 32'(pending_q), 32'd0);
        tick();
        tick();
        chk("t5_idle_valid", 32'(irq_valid), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        req_a[0] = 1'b0;
        tick();
        req_a[0] = 1'b1;
        tick();
        req_a[0] = 1'b0;
        tick();
        tick();
        chk_offer("t5_a0_again", 2'd0, 4'd0);
        irq_ack = 1'b1;
        req_a[0] = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t5_set_wins", 32'(pending_q), 32'd1);
        chk("t5_busy_svc", 32'(busy), 32'd1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        req_a[0] = 1'b0;
        tick();
        tick();
        chk_offer("t5_reoffer", 2'd0, 4'd0);

        // reset while offering
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6_rst_offer");

        // reset while in service
        write_mask(27'd0);
        req_b[1] = 1'b1;
        tick();
        req_b[1] = 1'b0;
        tick();
        tick();
        chk_offer("t6_b1", 2'd1, 4'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t6_svc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6_rst_svc");

        // disabled arbitration leaves a pending request idle
        write_mask(27'd0);
        enable = 1'b0;
        req_a[3] = 1'b1;
        tick();
        req_a[3] = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_dis_busy", 32'(busy), 32'd0);
        chk("t6_dis_valid", 32'(irq_valid), 32'd0);
        chk("t6_dis_pend", 32'(pending_q), 32'h8);
        enable = 1'b1;
        tick();
        tick();
        chk_offer("t6_en_a3", 2'd0, 4'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
